// File: rtl/address_register_arbiter_if.sv
// Requester and register-file bundle for the address register arbiter.
// Handshake: a requester raises *_REQ with its fields stable and holds them until its one-cycle *_ACK; REQ must be low in the cycle after ACK.
interface address_register_arbiter_if #(
    parameter int REG_WIDTH = 32
);
    logic                 SUPERVISOR_MODE;
    logic                 EA_REQ;
    logic                 EX_REQ;
    logic [1:0]           EA_OP;
    logic [1:0]           EX_OP;
    logic [2:0]           EA_REG;
    logic [2:0]           EX_REG;
    logic [1:0]           EA_SIZE;
    logic [1:0]           EX_SIZE;
    logic [REG_WIDTH-1:0] EA_WDATA;
    logic [REG_WIDTH-1:0] EX_WDATA;
    logic                 EA_ACK;
    logic                 EX_ACK;
    logic [REG_WIDTH-1:0] EA_RDATA;
    logic [REG_WIDTH-1:0] EX_RDATA;
    logic [2:0]           RF_SEL;
    logic                 RF_BANK;
    logic                 RF_WE;
    logic [REG_WIDTH-1:0] RF_WDATA;
    logic [REG_WIDTH-1:0] RF_RDATA;
    logic                 BUSY;

    modport master (
        output SUPERVISOR_MODE, EA_REQ, EX_REQ, EA_OP, EX_OP, EA_REG, EX_REG,
               EA_SIZE, EX_SIZE, EA_WDATA, EX_WDATA, RF_RDATA,
        input  EA_ACK, EX_ACK, EA_RDATA, EX_RDATA, RF_SEL, RF_BANK, RF_WE,
               RF_WDATA, BUSY
    );

    modport slave (
        input  SUPERVISOR_MODE, EA_REQ, EX_REQ, EA_OP, EX_OP, EA_REG, EX_REG,
               EA_SIZE, EX_SIZE, EA_WDATA, EX_WDATA, RF_RDATA,
        output EA_ACK, EX_ACK, EA_RDATA, EX_RDATA, RF_SEL, RF_BANK, RF_WE,
               RF_WDATA, BUSY
    );
endinterface

// File: rtl/address_register_arbiter.sv
// Shares the single-ported A0-A7 register file between the EA and EX units,
// performing reads, writes and (An)+ / -(An) read-modify-write updates.
module address_register_arbiter #(
    parameter int REG_WIDTH = 32,
    parameter bit EX_FIRST  = 1'b1
) (
    input  logic       CLK,
    input  logic       RESET_N,
    address_register_arbiter_if.slave bus,
    output logic [1:0] o_dbg_state
);
    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_UPDATE, S_DONE} state_t;

    state_t               r_state;
    state_t               w_next;
    logic                 r_gnt_ex;
    logic                 r_last_ex;
    logic                 r_sup;
    logic [1:0]           r_op;
    logic [1:0]           r_size;
    logic [2:0]           r_reg;
    logic [REG_WIDTH-1:0] r_wdata;
    logic [REG_WIDTH-1:0] r_adj;
    logic [REG_WIDTH-1:0] r_ea_rdata;
    logic [REG_WIDTH-1:0] r_ex_rdata;
    logic                 w_any_req;
    logic                 w_pick_ex;
    logic [REG_WIDTH-1:0] w_inc;
    logic [REG_WIDTH-1:0] w_minus;
    logic [REG_WIDTH-1:0] w_plus;

    assign w_any_req   = bus.EA_REQ | bus.EX_REQ;
    // On a tie the requester that was not granted last wins.
    assign w_pick_ex   = bus.EX_REQ & (~bus.EA_REQ | ~r_last_ex);
    assign w_minus     = bus.RF_RDATA - w_inc;
    assign w_plus      = bus.RF_RDATA + w_inc;
    assign o_dbg_state = r_state;
    assign bus.EA_RDATA = r_ea_rdata;
    assign bus.EX_RDATA = r_ex_rdata;
    assign bus.BUSY     = (r_state != S_IDLE);

    // Byte steps on A7 use 2 so the stack pointer stays even.
    always_comb begin
        w_inc = REG_WIDTH'(4);
        case (r_size)
            2'b00:   w_inc = (r_reg == 3'd7) ? REG_WIDTH'(2) : REG_WIDTH'(1);
            2'b01:   w_inc = REG_WIDTH'(2);
            default: w_inc = REG_WIDTH'(4);
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_any_req) w_next = S_ACCESS;
            S_ACCESS: w_next = r_op[1] ? S_UPDATE : S_DONE;
            S_UPDATE: w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.RF_SEL   = 3'd0;
        bus.RF_BANK  = 1'b0;
        bus.RF_WE    = 1'b0;
        bus.RF_WDATA = '0;
        bus.EA_ACK   = 1'b0;
        bus.EX_ACK   = 1'b0;
        case (r_state)
            S_ACCESS: begin
                bus.RF_SEL  = r_reg;
                bus.RF_BANK = r_sup & (r_reg == 3'd7);
                if (r_op == 2'b01) begin
                    bus.RF_WE    = 1'b1;
                    bus.RF_WDATA = r_wdata;
                end
            end
            S_UPDATE: begin
                bus.RF_SEL   = r_reg;
                bus.RF_BANK  = r_sup & (r_reg == 3'd7);
                bus.RF_WE    = 1'b1;
                bus.RF_WDATA = r_adj;
            end
            S_DONE: begin
                bus.EA_ACK = ~r_gnt_ex;
                bus.EX_ACK = r_gnt_ex;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_gnt_ex   <= 1'b0;
            r_last_ex  <= ~EX_FIRST;
            r_sup      <= 1'b0;
            r_op       <= 2'b00;
            r_size     <= 2'b00;
            r_reg      <= 3'd0;
            r_wdata    <= '0;
            r_adj      <= '0;
            r_ea_rdata <= '0;
            r_ex_rdata <= '0;
        end else begin
            if (r_state == S_IDLE && w_any_req) begin
                r_gnt_ex  <= w_pick_ex;
                r_last_ex <= w_pick_ex;
                r_sup     <= bus.SUPERVISOR_MODE;
                r_op      <= w_pick_ex ? bus.EX_OP    : bus.EA_OP;
                r_size    <= w_pick_ex ? bus.EX_SIZE  : bus.EA_SIZE;
                r_reg     <= w_pick_ex ? bus.EX_REG   : bus.EA_REG;
                r_wdata   <= w_pick_ex ? bus.EX_WDATA : bus.EA_WDATA;
            end
            // Plain writes leave the requester's previous result in place.
            if (r_state == S_ACCESS && r_op != 2'b01) begin
                r_adj <= r_op[0] ? w_minus : w_plus;
                if (r_gnt_ex) r_ex_rdata <= (r_op == 2'b11) ? w_minus : bus.RF_RDATA;
                else          r_ea_rdata <= (r_op == 2'b11) ? w_minus : bus.RF_RDATA;
            end
        end
    end
endmodule
